prog_load_run_ctrl: RTL and testbench

- Parametrised load/run sequencer between a host or bench stream and the multicycle computer's memory backdoor port.
- Accepts a stream of (address, data) words over a valid/ready handshake and writes them into memory while holding the memory mux on the backdoor side.
- On start, pulses CPU reset, runs the CPU until Done or timeout, and buffers every OutR value in a FIFO that the host drains through a second handshake.

---
 rtl/prog_load_run_ctrl.sv | 172 +++++++++++++++++
 tb/tb_prog_load_run_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_run_ctrl.sv
// Load/run sequencer for the multicycle computer: streams (addr,data) words into memory
// through the backdoor port, then resets and runs the CPU while buffering OutR values.
module prog_load_run_ctrl #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 8,
  parameter int CPU_RST_CYCLES = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int OUT_DEPTH      = 8
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_sel,
  output logic              cpu_rst,
  input  logic              cpu_done,
  input  logic              cpu_out_valid,
  input  logic [DATA_W-1:0] cpu_out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              run_done,
  output logic              run_timeout,
  output logic              out_overflow,
  output logic [ADDR_W:0]   load_count
);

  localparam int PTR_W   = $clog2(OUT_DEPTH);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > CPU_RST_CYCLES) ? TIMEOUT_CYCLES : CPU_RST_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0] LOAD_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LOAD_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]  PTR_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(CPU_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARMED, S_CPU_RST, S_RUN, S_END
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [DATA_W-1:0] memWdata_q;
  logic              memWe_q, memSel_q, cpuRst_q, busy_q;
  logic              runDone_q, runTimeout_q, overflow_q;
  logic [ADDR_W:0]   loadCount_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [DATA_W-1:0] fifoMem [OUT_DEPTH];
  logic [PTR_W:0]    wrPtr_q, rdPtr_q;
  logic              fifoEmpty, fifoFull, fifoPush, fifoPop, fifoWrite, fifoClr, ldFire;

  assign ld_ready  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_ARMED);
  assign ldFire    = ld_valid && ld_ready;
  assign fifoEmpty = (wrPtr_q == rdPtr_q);
  assign fifoFull  = (wrPtr_q[PTR_W] != rdPtr_q[PTR_W]) &&
                     (wrPtr_q[PTR_W-1:0] == rdPtr_q[PTR_W-1:0]);
  assign fifoPop   = !fifoEmpty && out_ready;
  assign fifoPush  = (state_q == S_RUN) && cpu_out_valid;
  // A pop frees a slot in the same cycle, so a full FIFO can still take the push.
  assign fifoWrite = fifoPush && (!fifoFull || fifoPop);
  assign fifoClr   = (state_q == S_CPU_RST) || ((state_q == S_IDLE) && ldFire);

  assign out_valid    = !fifoEmpty;
  assign out_data     = fifoMem[rdPtr_q[PTR_W-1:0]];
  assign mem_addr     = memAddr_q;
  assign mem_wdata    = memWdata_q;
  assign mem_we       = memWe_q;
  assign mem_sel      = memSel_q;
  assign cpu_rst      = cpuRst_q;
  assign busy         = busy_q;
  assign run_done     = runDone_q;
  assign run_timeout  = runTimeout_q;
  assign out_overflow = overflow_q;
  assign load_count   = loadCount_q;

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      memAddr_q    <= '0;
      memWdata_q   <= '0;
      memWe_q      <= 1'b0;
      memSel_q     <= 1'b1;
      cpuRst_q     <= 1'b1;
      busy_q       <= 1'b0;
      runDone_q    <= 1'b0;
      runTimeout_q <= 1'b0;
      overflow_q   <= 1'b0;
      loadCount_q  <= '0;
      cnt_q        <= '0;
    end else begin
      memWe_q <= ldFire;
      if (ldFire) begin
        memAddr_q  <= ld_addr;
        memWdata_q <= ld_data;
      end
      if (fifoPush && fifoFull && !fifoPop) overflow_q <= 1'b1;
      case (state_q)
        S_IDLE, S_LOAD, S_ARMED: begin
          // A load word always wins over start, even in ARMED.
          if (ldFire) begin
            state_q <= ld_last ? S_ARMED : S_LOAD;
            busy_q  <= !ld_last;
            if (state_q == S_IDLE) begin
              loadCount_q  <= LOAD_ONE;
              runDone_q    <= 1'b0;
              runTimeout_q <= 1'b0;
              overflow_q   <= 1'b0;
            end else if (loadCount_q != LOAD_MAX) begin
              loadCount_q <= loadCount_q + LOAD_ONE;
            end
          end else if ((state_q == S_ARMED) && start) begin
            state_q  <= S_CPU_RST;
            busy_q   <= 1'b1;
            memSel_q <= 1'b0;
            cpuRst_q <= 1'b1;
            cnt_q    <= '0;
          end
        end
        S_CPU_RST: begin
          if (cnt_q == RST_LAST) begin
            state_q  <= S_RUN;
            cpuRst_q <= 1'b0;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_RUN: begin
          if (cpu_done || (cnt_q == RUN_LAST)) begin
            state_q      <= S_END;
            cpuRst_q     <= 1'b1;
            memSel_q     <= 1'b1;
            runDone_q    <= cpu_done;
            runTimeout_q <= !cpu_done;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_END: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst || fifoClr) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      if (fifoPop)   rdPtr_q <= rdPtr_q + PTR_ONE;
      if (fifoWrite) wrPtr_q <= wrPtr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (fifoWrite) fifoMem[wrPtr_q[PTR_W-1:0]] <= cpu_out_data;
  end

endmodule

// File: tb/tb_prog_load_run_ctrl.sv
// Bench for prog_load_run_ctrl: directed load/run/timeout/overflow/reset sequence with
// random words and OutR values checked against a queue-based reference model.
module tb_prog_load_run_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 8;
  localparam int RST_CYC = 3;
  localparam int TMO     = 64;
  localparam int DEPTH   = 4;

  logic              clk = 1'b0;
  logic              Rst;
  logic              ld_valid, ld_last, start;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we, mem_sel, cpu_rst;
  logic              cpu_done, cpu_out_valid;
  logic [DATA_W-1:0] cpu_out_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy, run_done, run_timeout, out_overflow;
  logic [ADDR_W:0]   load_count;

  int nCompared   = 0;
  int nMismatched = 0;
  int expLoadCount;
  logic [DATA_W-1:0] expQ[$];
  logic expOverflow;

  always #5 clk = ~clk;

  prog_load_run_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CPU_RST_CYCLES(RST_CYC),
    .TIMEOUT_CYCLES(TMO), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .Rst(Rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_last(ld_last), .start(start),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_sel(mem_sel),
    .cpu_rst(cpu_rst), .cpu_done(cpu_done), .cpu_out_valid(cpu_out_valid),
    .cpu_out_data(cpu_out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .run_done(run_done), .run_timeout(run_timeout),
    .out_overflow(out_overflow), .load_count(load_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offers one load word; the write must appear on the backdoor exactly one cycle later.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic last, input logic first);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    if (first) expLoadCount = 1;
    else if (expLoadCount < (1 << ADDR_W)) expLoadCount++;
    tick();
    checkOutput("memWe", 32'(mem_we), 32'd1);
    checkOutput("memAddr", 32'(mem_addr), 32'(a));
    checkOutput("memData", 32'(mem_wdata), 32'(d));
    checkOutput("loadCount", 32'(load_count), 32'(expLoadCount));
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic startRun(output int rstCycles);
    start = 1'b1;
    tick();
    start = 1'b0;
    rstCycles = 0;
    while (cpu_rst === 1'b1 && mem_sel === 1'b0 && rstCycles < 20) begin
      rstCycles++;
      tick();
    end
  endtask

  task automatic cpuStrobe(input logic [DATA_W-1:0] v, input logic pop, input logic done);
    cpu_out_valid = 1'b1;
    cpu_out_data  = v;
    out_ready     = pop;
    cpu_done      = done;
    if (pop && expQ.size() > 0) void'(expQ.pop_front());
    if (expQ.size() < DEPTH) expQ.push_back(v);
    else expOverflow = 1'b1;
    tick();
    cpu_out_valid = 1'b0;
    out_ready     = 1'b0;
    cpu_done      = 1'b0;
  endtask

  task automatic drainFifo();
    while (expQ.size() > 0) begin
      checkOutput("outValid", 32'(out_valid), 32'd1);
      checkOutput("outData", 32'(out_data), 32'(expQ[0]));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      void'(expQ.pop_front());
    end
    checkOutput("outEmpty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=no finish required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rstCycles;
    int runCycles;
    logic [DATA_W-1:0] plan [3];
    Rst = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; start = 1'b0;
    ld_addr = '0; ld_data = '0; cpu_done = 1'b0; cpu_out_valid = 1'b0;
    cpu_out_data = '0; out_ready = 1'b0; expOverflow = 1'b0; expLoadCount = 0;
    plan[0] = 16'h0001; plan[1] = 16'h0021; plan[2] = 16'hFFE0;

    repeat (3) tick();
    checkOutput("rstMemSel", 32'(mem_sel), 32'd1);
    checkOutput("rstCpuRst", 32'(cpu_rst), 32'd1);
    checkOutput("rstMemWe", 32'(mem_we), 32'd0);
    checkOutput("rstOutValid", 32'(out_valid), 32'd0);
    checkOutput("rstFlags", {29'd0, run_done, run_timeout, out_overflow}, 32'd0);
    checkOutput("rstLdReady", 32'(ld_ready), 32'd1);
    checkOutput("rstLoadCount", 32'(load_count), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    Rst = 1'b1;

    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("idleStartMemSel", 32'(mem_sel), 32'd1);
    checkOutput("idleStartBusy", 32'(busy), 32'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus((i < 5) ? ADDR_W'(8'h80 + i) : ADDR_W'(i - 5), DATA_W'($urandom),
                    (i == 13), (i == 0));
      if (i == 0) checkOutput("loadBusy", 32'(busy), 32'd1);
    end
    checkOutput("armedBusy", 32'(busy), 32'd0);
    tick();
    checkOutput("weDropped", 32'(mem_we), 32'd0);
    checkOutput("armedLoadCount", 32'(load_count), 32'd14);
    checkOutput("armedLdReady", 32'(ld_ready), 32'd1);

    start = 1'b1;
    applyStimulus(ADDR_W'(9), DATA_W'($urandom), 1'b1, 1'b0);
    start = 1'b0;
    checkOutput("loadWinsMemSel", 32'(mem_sel), 32'd1);
    tick();
    checkOutput("loadWinsNoRun", 32'(mem_sel), 32'd1);
    checkOutput("loadWinsBusy", 32'(busy), 32'd0);

    startRun(rstCycles);
    checkOutput("cpuRstCycles", 32'(rstCycles), 32'(RST_CYC));
    checkOutput("runCpuRst", 32'(cpu_rst), 32'd0);
    checkOutput("runMemSel", 32'(mem_sel), 32'd0);
    checkOutput("runBusy", 32'(busy), 32'd1);
    checkOutput("runLdReady", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cpuStrobe(plan[i], 1'b0, 1'b0);
      repeat ($urandom_range(2)) tick();
    end
    cpuStrobe(DATA_W'($urandom), 1'b0, 1'b1);
    checkOutput("doneFlag", 32'(run_done), 32'd1);
    checkOutput("doneNoTimeout", 32'(run_timeout), 32'd0);
    checkOutput("endMemSel", 32'(mem_sel), 32'd1);
    checkOutput("endCpuRst", 32'(cpu_rst), 32'd1);
    checkOutput("endBusy", 32'(busy), 32'd1);
    tick();
    checkOutput("idleBusy", 32'(busy), 32'd0);
    drainFifo();
    checkOutput("noOverflow", 32'(out_overflow), 32'(expOverflow));

    applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 1'b1, 1'b1);
    checkOutput("stickyCleared", 32'(run_done), 32'd0);
    startRun(rstCycles);
    runCycles = 0;
    while (cpu_rst === 1'b0 && runCycles < 200) begin
      runCycles++;
      tick();
    end
    checkOutput("timeoutCycles", 32'(runCycles), 32'(TMO));
    checkOutput("timeoutFlag", 32'(run_timeout), 32'd1);
    checkOutput("timeoutNoDone", 32'(run_done), 32'd0);
    checkOutput("timeoutMemSel", 32'(mem_sel), 32'd1);
    tick();
    checkOutput("timeoutIdle", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("idleStartIgnored", 32'(mem_sel), 32'd1);

    expOverflow = 1'b0;
    applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 1'b1, 1'b1);
    startRun(rstCycles);
    for (int i = 0; i < 6; i++) begin
      cpuStrobe(DATA_W'($urandom), 1'b0, 1'b0);
      if (i == 3) checkOutput("fullNoLoss", 32'(out_overflow), 32'd0);
    end
    checkOutput("overflowFlag", 32'(out_overflow), 32'(expOverflow));
    checkOutput("fullHead", 32'(out_data), 32'(expQ[0]));
    cpuStrobe(DATA_W'($urandom), 1'b1, 1'b0);
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    checkOutput("ovfRunDone", 32'(run_done), 32'd1);
    checkOutput("overflowSticky", 32'(out_overflow), 32'd1);
    drainFifo();

    applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 1'b1, 1'b1);
    checkOutput("overflowCleared", 32'(out_overflow), 32'd0);
    startRun(rstCycles);
    cpuStrobe(DATA_W'($urandom), 1'b0, 1'b0);
    cpuStrobe(DATA_W'($urandom), 1'b0, 1'b0);
    checkOutput("preResetValid", 32'(out_valid), 32'd1);
    Rst = 1'b0;
    tick();
    expQ.delete();
    checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
    checkOutput("midRstMemSel", 32'(mem_sel), 32'd1);
    checkOutput("midRstCpuRst", 32'(cpu_rst), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstLoadCount", 32'(load_count), 32'd0);
    checkOutput("midRstLdReady", 32'(ld_ready), 32'd1);
    Rst = 1'b1;
    tick();
    checkOutput("postRstMemWe", 32'(mem_we), 32'd0);
    checkOutput("postRstEmpty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
